// File: rtl/stage_wb_scoreboard.sv
// stage_wb_scoreboard
// Register-write scoreboard seen from the producer side of the RAW-hazard path.
// An ID-stage issue that writes a register marks it pending. A WB-stage
// retirement releases it. stall holds ID while any of these is true:
//    - a source it reads has an outstanding write,
//    - its destination counter is saturated,
//    - the total in-flight budget is exhausted.
// Register 0 is never tracked.
// Optional build macro: SCOREBOARD_STATS_EN adds the stall_cycles output, a
// saturating count of stalled cycles that is cleared only by rst_n.
module stage_wb_scoreboard #(
   parameter int REG_NUM      = 32,
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               issue_valid,
   input  logic                               issue_we,
   input  logic [$clog2(REG_NUM)-1:0]         issue_rd,
   input  logic                               id_uses_a,
   input  logic                               id_uses_b,
   input  logic [$clog2(REG_NUM)-1:0]         id_read_addr_a,
   input  logic [$clog2(REG_NUM)-1:0]         id_read_addr_b,
   input  logic                               wb_valid,
   input  logic [$clog2(REG_NUM)-1:0]         wb_rd,
   output logic                               stall,
   output logic [REG_NUM-1:0]                 pending_mask,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
   output logic                               full,
   output logic                               err_underflow
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0]                        stall_cycles
`endif
);

   localparam int IDX_W = $clog2(REG_NUM);
   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [INF_W-1:0] INF_ZERO = {INF_W{1'b0}};
   localparam logic [INF_W-1:0] INF_ONE  = INF_W'(1'b1);
   localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   // Architectural state. Entry 0 of the counter array is held at zero.
   logic [CNT_W-1:0]   cnt_r [REG_NUM];
   logic [INF_W-1:0]   inflight_r;
   logic [REG_NUM-1:0] pending_mask_r;
   logic               full_r;
   logic               err_underflow_r;

   // Next-state and decode signals
   logic [CNT_W-1:0]   cnt_nxt_s [REG_NUM];
   logic [INF_W-1:0]   inflight_nxt_s;
   logic [REG_NUM-1:0] pending_nxt_s;
   logic               full_nxt_s;
   logic               haz_a_s;
   logic               haz_b_s;
   logic               haz_w_s;
   logic               haz_f_s;
   logic               stall_s;
   logic               accept_s;
   logic               wb_hit_s;
   logic               underflow_s;

   // Hazard detection from registered counters only.
   // A same-cycle WB is deliberately not forwarded into the stall decision.
   always_comb begin
      haz_a_s     = id_uses_a && (id_read_addr_a != IDX_ZERO) && (cnt_r[id_read_addr_a] != CNT_ZERO);
      haz_b_s     = id_uses_b && (id_read_addr_b != IDX_ZERO) && (cnt_r[id_read_addr_b] != CNT_ZERO);
      haz_w_s     = issue_we && (issue_rd != IDX_ZERO) && (cnt_r[issue_rd] == CNT_MAX);
      haz_f_s     = issue_we && (issue_rd != IDX_ZERO) && full_r;
      stall_s     = issue_valid && (haz_a_s || haz_b_s || haz_w_s || haz_f_s);
      accept_s    = issue_valid && !stall_s && issue_we && (issue_rd != IDX_ZERO);
      wb_hit_s    = wb_valid && (wb_rd != IDX_ZERO) && (cnt_r[wb_rd] != CNT_ZERO);
      underflow_s = wb_valid && (wb_rd != IDX_ZERO) && (cnt_r[wb_rd] == CNT_ZERO);
   end

   assign stall = stall_s;

   // Per-register and total counter updates. Flush overrides issue and WB.
   always_comb begin
      for (int i = 0; i < REG_NUM; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
      end
      inflight_nxt_s = inflight_r;
      if (flush) begin
         for (int i = 0; i < REG_NUM; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
         end
         inflight_nxt_s = INF_ZERO;
      end else begin
         cnt_nxt_s[0] = CNT_ZERO;
         for (int i = 1; i < REG_NUM; i++) begin
            if (accept_s && (issue_rd == IDX_W'(i)) && !(wb_hit_s && (wb_rd == IDX_W'(i)))) begin
               cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (wb_hit_s && (wb_rd == IDX_W'(i)) && !(accept_s && (issue_rd == IDX_W'(i)))) begin
               cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
               cnt_nxt_s[i] = cnt_r[i];
            end
         end
         if (accept_s && !wb_hit_s) begin
            inflight_nxt_s = inflight_r + INF_ONE;
         end else if (wb_hit_s && !accept_s) begin
            inflight_nxt_s = inflight_r - INF_ONE;
         end else begin
            inflight_nxt_s = inflight_r;
         end
      end
   end

   // Derive the next pending mask and full flag so both outputs come from flops
   always_comb begin
      pending_nxt_s = {REG_NUM{1'b0}};
      for (int i = 1; i < REG_NUM; i++) begin
         pending_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
      end
      full_nxt_s = (inflight_nxt_s == INF_MAX);
   end

   // State register. The sticky underflow flag survives flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
         inflight_r      <= INF_ZERO;
         pending_mask_r  <= {REG_NUM{1'b0}};
         full_r          <= 1'b0;
         err_underflow_r <= 1'b0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         inflight_r      <= inflight_nxt_s;
         pending_mask_r  <= pending_nxt_s;
         full_r          <= full_nxt_s;
         err_underflow_r <= err_underflow_r | (underflow_s & ~flush);
      end
   end

   assign pending_mask  = pending_mask_r;
   assign inflight_cnt  = inflight_r;
   assign full          = full_r;
   assign err_underflow = err_underflow_r;

`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles_r;

   // Saturating stalled-cycle counter, deliberately left untouched by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_r <= 32'd0;
      end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_stage_wb_scoreboard.sv
// Directed self-checking bench for stage_wb_scoreboard (default parameters).
// The stall_cycles checks are compiled in when SCOREBOARD_STATS_EN is defined.
module tb_stage_wb_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        issue_valid;
   logic        issue_we;
   logic [4:0]  issue_rd;
   logic        id_uses_a;
   logic        id_uses_b;
   logic [4:0]  id_read_addr_a;
   logic [4:0]  id_read_addr_b;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        stall;
   logic [31:0] pending_mask;
   logic [2:0]  inflight_cnt;
   logic        full;
   logic        err_underflow;
`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int errors;
   int checks;

   stage_wb_scoreboard dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .issue_valid    (issue_valid),
      .issue_we       (issue_we),
      .issue_rd       (issue_rd),
      .id_uses_a      (id_uses_a),
      .id_uses_b      (id_uses_b),
      .id_read_addr_a (id_read_addr_a),
      .id_read_addr_b (id_read_addr_b),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .stall          (stall),
      .pending_mask   (pending_mask),
      .inflight_cnt   (inflight_cnt),
      .full           (full),
      .err_underflow  (err_underflow)
`ifdef SCOREBOARD_STATS_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      flush          = 1'b0;
      issue_valid    = 1'b0;
      issue_we       = 1'b0;
      issue_rd       = 5'd0;
      id_uses_a      = 1'b0;
      id_uses_b      = 1'b0;
      id_read_addr_a = 5'd0;
      id_read_addr_b = 5'd0;
      wb_valid       = 1'b0;
      wb_rd          = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #3;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 00000000", pending_mask); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_underflow); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_raw();
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall: got %0b want 0", stall); end
      tick();
      checks++; if (pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL raw_pending_set: got %h want 00000020", pending_mask); end
      checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL raw_inflight_1: got %0d want 1", inflight_cnt); end
      issue_we = 1'b0; issue_rd = 5'd0; id_uses_a = 1'b1; id_read_addr_a = 5'd5;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_read_stall: got %0b want 1", stall); end
      tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_hold_stall: got %0b want 1", stall); end
      tick();
      wb_valid = 1'b1; wb_rd = 5'd5;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_same_cycle_wb_stall: got %0b want 1", stall); end
      tick();
      wb_valid = 1'b0; wb_rd = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_release_stall: got %0b want 0", stall); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL raw_pending_clear: got %h want 00000000", pending_mask); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_inflight_0: got %0d want 0", inflight_cnt); end
      idle();
      tick();
   endtask

   task automatic test_x0();
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_issue_stall: got %0b want 0", stall); end
      tick();
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL x0_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL x0_pending: got %h want 00000000", pending_mask); end
      issue_we = 1'b0; id_uses_a = 1'b1; id_uses_b = 1'b1;
      id_read_addr_a = 5'd0; id_read_addr_b = 5'd0;
      wb_valid = 1'b1; wb_rd = 5'd0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_read_stall: got %0b want 0", stall); end
      tick();
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL x0_wb_err: got %0b want 0", err_underflow); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL x0_wb_inflight: got %0d want 0", inflight_cnt); end
      idle();
   endtask

   task automatic test_full();
      idle();
      issue_valid = 1'b1; issue_we = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         issue_rd = 5'(r);
         tick();
      end
      checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL full_inflight_4: got %0d want 4", inflight_cnt); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag_set: got %0b want 1", full); end
      checks++; if (pending_mask !== 32'h0000_001E) begin errors++; $display("FAIL full_pending: got %h want 0000001e", pending_mask); end
      issue_rd = 5'd6;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_fifth_stall: got %0b want 1", stall); end
      tick();
      wb_valid = 1'b1; wb_rd = 5'd2;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_wb_same_cycle_stall: got %0b want 1", stall); end
      tick();
      wb_valid = 1'b0; wb_rd = 5'd0;
      #1;
      checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL full_after_wb_inflight: got %0d want 3", inflight_cnt); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_after_wb_flag: got %0b want 0", full); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_after_wb_stall: got %0b want 0", stall); end
      tick();
      checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL full_accept_inflight: got %0d want 4", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0000_005A) begin errors++; $display("FAIL full_accept_pending: got %h want 0000005a", pending_mask); end
      issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
      wb_valid = 1'b1;
      wb_rd = 5'd1; tick();
      wb_rd = 5'd3; tick();
      wb_rd = 5'd4; tick();
      wb_rd = 5'd6; tick();
      idle();
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL full_drain_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL full_drain_pending: got %h want 00000000", pending_mask); end
   endtask

   task automatic test_saturate();
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd7;
      tick(); tick(); tick();
      checks++; if (pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sat_pending: got %h want 00000080", pending_mask); end
      checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL sat_inflight_3: got %0d want 3", inflight_cnt); end
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_hazw_stall: got %0b want 1", stall); end
      wb_valid = 1'b1; wb_rd = 5'd7;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_hazw_wb_stall: got %0b want 1", stall); end
      tick();
      checks++; if (inflight_cnt !== 3'd2) begin errors++; $display("FAIL sat_wb_only_inflight: got %0d want 2", inflight_cnt); end
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_unsat_stall: got %0b want 0", stall); end
      tick();
      checks++; if (inflight_cnt !== 3'd2) begin errors++; $display("FAIL sat_same_reg_inflight: got %0d want 2", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0000_0080) begin errors++; $display("FAIL sat_same_reg_pending: got %h want 00000080", pending_mask); end
      issue_rd = 5'd8;
      tick();
      checks++; if (inflight_cnt !== 3'd2) begin errors++; $display("FAIL sat_diff_reg_inflight: got %0d want 2", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0000_0180) begin errors++; $display("FAIL sat_diff_reg_pending: got %h want 00000180", pending_mask); end
      issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
      wb_rd = 5'd7; tick();
      wb_rd = 5'd8; tick();
      idle();
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL sat_drain_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL sat_drain_pending: got %h want 00000000", pending_mask); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sat_no_err: got %0b want 0", err_underflow); end
   endtask

   task automatic test_underflow();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd9;
      tick();
      idle();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err_set: got %0b want 1", err_underflow); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL uf_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL uf_pending: got %h want 00000000", pending_mask); end
      tick();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err_sticky: got %0b want 1", err_underflow); end
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
      tick();
      checks++; if (pending_mask !== 32'h0000_0008) begin errors++; $display("FAIL uf_pre_flush_pending: got %h want 00000008", pending_mask); end
      issue_rd = 5'd10; flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
      tick();
      idle();
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL flush_pending: got %h want 00000000", pending_mask); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL flush_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL flush_full: got %0b want 0", full); end
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL flush_err_kept: got %0b want 1", err_underflow); end
   endtask

   task automatic test_async_reset();
      idle();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd11;
      tick();
      issue_we = 1'b0; issue_rd = 5'd0; id_uses_a = 1'b1; id_read_addr_a = 5'd11;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL arst_pre_stall: got %0b want 1", stall); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %0b want 0", stall); end
      checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL arst_pending: got %h want 00000000", pending_mask); end
      checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL arst_inflight: got %0d want 0", inflight_cnt); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full: got %0b want 0", full); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL arst_err: got %0b want 0", err_underflow); end
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

`ifdef SCOREBOARD_STATS_EN
   task automatic test_stats();
      idle();
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL stats_start: got %0d want 0", stall_cycles); end
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
      tick();
      issue_we = 1'b0; issue_rd = 5'd0; id_uses_a = 1'b1; id_read_addr_a = 5'd5;
      for (int k = 0; k < 5; k++) begin
         tick();
      end
      checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_five: got %0d want 5", stall_cycles); end
      idle();
      wb_valid = 1'b1; wb_rd = 5'd5; flush = 1'b1;
      tick();
      idle();
      checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_flush_kept: got %0d want 5", stall_cycles); end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_raw();
      test_x0();
      test_full();
      test_saturate();
      test_underflow();
      test_async_reset();
`ifdef SCOREBOARD_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stage_wb_scoreboard.md
Name: stage_wb_scoreboard

Overview:
- Register-write scoreboard for the in-order pipeline, working from the producer end of the RAW-hazard interface.
- ID-stage issue marks a destination register pending; WB-stage retirement releases it.
- Drives `stall` back to ID while a source or destination collides with an in-flight write.
- Covers multi-cycle producers (loads, later mul/div) that a single-stage lookahead check cannot.

Parameters:
- REG_NUM, 32, number of architectural registers; index width is $clog2(REG_NUM).
- CNT_W, 2, width of the per-register pending counter (max 2^CNT_W-1 outstanding writes to one register).
- MAX_INFLIGHT, 4, maximum total outstanding writes across all registers.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush; clears all pending state.
- issue_valid  input  1  ID holds a valid instruction attempting to advance.
- issue_we  input  1  ID instruction writes a register.
- issue_rd  input  $clog2(REG_NUM)  ID destination register.
- id_uses_a  input  1  ID instruction reads rs1.
- id_uses_b  input  1  ID instruction reads rs2.
- id_read_addr_a  input  $clog2(REG_NUM)  rs1 index.
- id_read_addr_b  input  $clog2(REG_NUM)  rs2 index.
- wb_valid  input  1  WB retires a register write this cycle.
- wb_rd  input  $clog2(REG_NUM)  WB destination register.
- stall  output  1  hold ID; combinational from registered state and ID inputs.
- pending_mask  output  REG_NUM  bit i = 1 when counter i is non-zero.
- inflight_cnt  output  $clog2(MAX_INFLIGHT+1)  total outstanding writes.
- full  output  1  inflight_cnt == MAX_INFLIGHT.
- err_underflow  output  1  sticky; set on WB to a register with zero count.

Behaviour:
- Reset (rst_n low, async): all per-register counters 0, inflight_cnt 0, err_underflow 0. Outputs: stall 0, pending_mask all 0, full 0.
- Register 0 is never tracked.
  - Issue or WB with rd = 0 has no effect.
  - A read of x0 never stalls.
- stall = issue_valid & (hazA | hazB | hazW | hazF):
  - hazA = id_uses_a & (a != 0) & cnt[a] != 0.
  - hazB = id_uses_b & (b != 0) & cnt[b] != 0.
  - hazW = issue_we & (rd != 0) & cnt[rd] == 2^CNT_W-1 (saturation guard).
  - hazF = issue_we & (rd != 0) & full.
- Same-cycle WB does not release stall; ID sees the release one cycle after wb_valid (register file write-before-read not assumed).
- accept = issue_valid & ~stall & issue_we & rd != 0.
- On accept: cnt[issue_rd] +1 and inflight_cnt +1 at the next edge.
- On valid WB (wb_valid, wb_rd != 0, cnt[wb_rd] != 0): cnt[wb_rd] -1 and inflight_cnt -1.
- Simultaneous accept and WB:
  - Same register: counter unchanged.
  - Different registers: both applied.
  - inflight_cnt nets to unchanged.
  - An accept while full is impossible (hazF), but a WB in a full cycle frees a slot for the following cycle only.
- Underflow: WB to a register with cnt 0 leaves state unchanged and sets err_underflow. err_underflow clears only on reset.
- flush (sync, priority over issue and WB): next edge sets all counters and inflight_cnt to 0. Any issue or WB in that cycle is dropped. err_underflow is unaffected.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- When defined, adds output `stall_cycles` [31:0]:
  - Increments each clk where stall = 1.
  - Saturates at 32'hFFFFFFFF.
  - Reset to 0 by rst_n only (not by flush).
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Issue rd=5 (we=1), next cycle ID reads a=5 with uses_a=1 → stall=1, pending_mask[5]=1. Hold two cycles, wb_valid rd=5 → stall=0 the cycle after WB, pending_mask[5]=0.
- Issue rd=0 then read a=0, b=0 → stall=0 throughout, inflight_cnt=0.
- Four accepted issues to rd=1,2,3,4 → full=1. Fifth issue rd=6 → stall=1. wb rd=2 → next cycle stall=0 and issue accepted, inflight_cnt=4.
- Three issues to rd=7 (CNT_W=2) → cnt saturates at 3. Fourth issue rd=7 → stall via hazW. Same-cycle issue rd=7 with wb rd=7 → pending_mask[7] stays 1, inflight_cnt unchanged.
- wb_valid rd=9 with nothing pending → err_underflow=1 stays set, counters unchanged. flush with wb rd=3 pending → all cleared, err_underflow remains 1.
- With SCOREBOARD_STATS_EN: 5 stalled cycles → stall_cycles=5. Assert rst_n=0 between edges → all outputs 0 immediately.
